// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DPS, CHECK} state_t;

    localparam int   FRAME_BITS   = 11;
    localparam logic START_BIT    = 1'b0;
    localparam logic STOP_BIT     = 1'b1;
    localparam int   LAST_BIT_IDX = 9;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Small first-word fall-through FIFO holding received scan codes.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: ps2c glitch filter, frame checks,
// inactivity timeout, and a scan-code FIFO for the keyboard decoder.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [FILTER_LEN-1:0] filt;
    logic                  f_ps2c, f_ps2c_next, fall_edge;
    logic [1:0]            d_sync;
    state_t                state;
    logic [3:0]            n;
    logic [FRAME_BITS-1:0] b;
    logic [TW-1:0]         tcnt;
    logic                  fmt_ok, par_ok, pop, push;

    always_comb begin
        f_ps2c_next = f_ps2c;
        if (&filt)       f_ps2c_next = 1'b1;
        else if (~|filt) f_ps2c_next = 1'b0;
    end

    assign fall_edge = f_ps2c & ~f_ps2c_next;
    assign busy      = (state != IDLE);
    assign fmt_ok    = (b[0] == START_BIT) && (b[FRAME_BITS-1] == STOP_BIT);
    assign par_ok    = odd_parity_ok(b[8:1], b[9]);
    assign pop       = rd_en & ~empty;
    // A pop in the CHECK cycle frees a slot, so a full FIFO can still accept.
    assign push      = (state == CHECK) & fmt_ok & par_ok & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= '0;
            f_ps2c <= 1'b0;
            d_sync <= '0;
        end else begin
            filt   <= {ps2c, filt[FILTER_LEN-1:1]};
            f_ps2c <= f_ps2c_next;
            d_sync <= {d_sync[0], ps2d};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            n          <= '0;
            b          <= '0;
            tcnt       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (fall_edge & rx_en) begin
                        b     <= {d_sync[1], b[FRAME_BITS-1:1]};
                        n     <= 4'(LAST_BIT_IDX);
                        state <= DPS;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        b    <= {d_sync[1], b[FRAME_BITS-1:1]};
                        tcnt <= '0;
                        if (n == '0) state <= CHECK;
                        else         n     <= n - 4'd1;
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    tcnt  <= '0;
                    if (!fmt_ok)               frame_err  <= 1'b1;
                    else if (!par_ok)          parity_err <= 1'b1;
                    else if (full && !pop)     overflow   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ps2_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (b[8:1]),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized frames against a queue-based model of the receiver.
module tb_ps2_rx_fifo;
    localparam int FL   = 8;
    localparam int FD   = 4;
    localparam int TO   = 300;
    localparam int HALF = 25;

    logic clk = 1'b0;
    logic reset, ps2c, ps2d, rx_en, rd_en;
    logic [7:0] dout;
    logic empty, full, busy, parity_err, frame_err, overflow;
    logic [$clog2(FD):0] count;

    int n_assert = 0, n_fail = 0;
    int perr_seen = 0, ferr_seen = 0, ovf_seen = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
        .busy(busy), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (parity_err === 1'b1) perr_seen++;
        if (frame_err === 1'b1)  ferr_seen++;
        if (overflow === 1'b1)   ovf_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    function automatic logic [10:0] mk(input logic [7:0] d, input int kind);
        logic st, par, sp;
        st  = (kind == 3);
        par = ~(^d) ^ (kind == 1);
        sp  = (kind != 2);
        return {sp, par, d, st};
    endfunction

    // With pop_chk, rd_en is raised for the single CHECK cycle: the filter
    // needs FL low samples, the edge registers one cycle later, then CHECK.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_chk, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                tick(4); ps2c = 1'b0; tick(FL - 1); ps2c = 1'b1; tick(HALF - 4 - (FL - 1));
            end else begin
                tick(HALF);
            end
            ps2c = 1'b0;
            if (pop_chk && i == nbits - 1) begin
                tick(FL + 1); rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(HALF - FL - 2);
            end else begin
                tick(HALF);
            end
            ps2c = 1'b1;
        end
        tick(HALF);
    endtask

    task automatic model_frame(input logic [7:0] d, input int kind, input bit pop_chk);
        if (pop_chk && q.size() > 0) void'(q.pop_front());
        if (kind == 2 || kind == 3) exp_ferr++;
        else if (kind == 1)         exp_perr++;
        else if (q.size() == FD)    exp_ovf++;
        else                        q.push_back(d);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(q.size() == FD));
        chk({tag, ".busy"},  32'(busy),  32'd0);
        if (q.size() > 0) chk({tag, ".dout"}, 32'(dout), 32'(q[0]));
        chk({tag, ".perr"}, 32'(perr_seen), 32'(exp_perr));
        chk({tag, ".ferr"}, 32'(ferr_seen), 32'(exp_ferr));
        chk({tag, ".ovf"},  32'(ovf_seen),  32'(exp_ovf));
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input int kind, input bit pop_chk, input bit glitch);
        send_bits(mk(d, kind), 11, pop_chk, glitch);
        if (rx_en) model_frame(d, kind, pop_chk);
        check_state(tag);
    endtask

    task automatic pop(input string tag);
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        tick(1);
        check_state(tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"},  32'(full),  32'd0);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".busy"},  32'(busy),  32'd0);
        chk({tag, ".dout"},  32'(dout),  32'd0);
        chk({tag, ".pulses"}, 32'(parity_err | frame_err | overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int r, kind;
        bit pc, gl;

        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
        tick(3);
        check_reset("rst");
        reset = 1'b0;
        tick(FL + 5);

        frame("good_1c", 8'h1C, 0, 0, 0);
        pop("pop_1c");
        frame("par_1c", 8'h1C, 1, 0, 0);
        frame("stop_1c", 8'h1C, 2, 0, 0);
        frame("good_f0", 8'hF0, 0, 0, 0);

        // Partial frame then silence: the timeout must abort it.
        send_bits(mk(8'hAA, 0), 4, 0, 0);
        tick(TO + 10);
        exp_ferr++;
        check_state("timeout");
        frame("good_5a", 8'h5A, 0, 0, 0);
        pop("pop_f0");
        pop("pop_5a");

        for (int i = 1; i <= 4; i++) frame("fill", 8'(i), 0, 0, 0);
        frame("ovf_05", 8'h05, 0, 0, 0);
        for (int i = 0; i < 5; i++) pop("drain");

        for (int i = 1; i <= 4; i++) frame("refill", 8'(8'h11 * i), 0, 0, 0);
        frame("full_pushpop", 8'h55, 0, 1, 0);
        frame("start_bad", 8'h3C, 3, 0, 0);
        for (int i = 0; i < 4; i++) pop("drain2");

        frame("glitch_a5", 8'hA5, 0, 0, 1);

        rx_en = 1'b0;
        frame("rx_off", 8'h3C, 0, 0, 0);
        rx_en = 1'b1;

        frame("pre_rst", 8'h66, 0, 0, 0);
        send_bits(mk(8'h77, 0), 5, 0, 0);
        reset = 1'b1;
        tick(2);
        check_reset("mid_rst");
        q.delete();
        reset = 1'b0;
        tick(FL + 5);
        frame("post_rst", 8'h77, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            d    = 8'($urandom);
            r    = int'($urandom_range(0, 9));
            kind = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
            pc   = ($urandom_range(0, 3) == 0);
            gl   = ($urandom_range(0, 3) == 0);
            frame("rand", d, kind, pc, gl);
            if ($urandom_range(0, 2) == 0) pop("rand_pop");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver. It extends the basic shift-and-tick keyboard receiver with a configurable ps2c glitch filter, start/stop/odd-parity checking, an inactivity timeout that aborts partial frames, and an output FIFO with a read handshake. It sits between the PS/2 pins and the keyboard decode logic, so scan codes arriving in bursts (for example E0/F0 prefixes) are not lost while the consumer is busy.

Parameters:
FILTER_LEN, 8, number of consecutive equal ps2c samples required to change the filtered clock (>=2)
FIFO_DEPTH, 4, scan-code FIFO entries (power of 2, >=2)
TIMEOUT_CYC, 20000, clk cycles without a filtered falling edge before a partial frame is aborted

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
ps2c  in  1  raw PS/2 clock pin
ps2d  in  1  raw PS/2 data pin
rx_en  in  1  enables the start of a new frame
rd_en  in  1  pop request; ignored while empty
dout  out  8  FIFO head (first-word fall-through)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH)+1  number of entries held
busy  out  1  high while a frame is in progress (state != IDLE)
parity_err  out  1  one-cycle pulse: frame dropped, bad parity
frame_err  out  1  one-cycle pulse: frame dropped, bad start/stop bit or timeout
overflow  out  1  one-cycle pulse: good frame dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. Reset clears the filter to 0, f_ps2c to 0, state to IDLE, all counters and pointers to 0, and every pulse to 0. After reset, empty=1, full=0, count=0, busy=0, dout=0.
- ps2d passes through a 2-flop synchroniser. ps2c feeds the FILTER_LEN shift register directly.
- Filtered clock f_ps2c: goes to 1 when the filter holds all ones, goes to 0 when it holds all zeros, otherwise holds its value.
- fall_edge = f_ps2c_reg & ~f_ps2c_next. ps2d is sampled on the cycle fall_edge is asserted.
- Frame format: start(0), d0..d7 LSB first, parity, stop(1). That is 11 bits, shifted right into b[10:0].
- FSM states:
  - IDLE: on fall_edge & rx_en, shift in the bit and set n=9, then go to DPS. A start bit of 1 still enters DPS; it is caught in CHECK.
  - DPS: on each fall_edge, shift; if n==0 go to CHECK, else decrement n.
  - CHECK: exactly one cycle, always returns to IDLE. Priority of the checks:
    - b[0]!=0 or b[10]!=1 -> frame_err.
    - else ^b[9:1]!=1 (odd parity) -> parity_err.
    - else if full and no simultaneous pop -> overflow, data dropped.
    - else push b[8:1].
- Timeout: the counter clears on every fall_edge and in IDLE, and increments in DPS. When it reaches TIMEOUT_CYC-1 in DPS: go to IDLE, pulse frame_err, discard the partial frame. There is no timeout in CHECK.
- rx_en only gates frame start. Deasserting it mid-frame does not abort the frame.
- FIFO:
  - A push becomes visible the cycle after CHECK (empty falls, count increments).
  - A pop advances the head the cycle after rd_en.
  - Push and pop in the same cycle are both accepted and count is unchanged; this includes the full case, where no overflow is flagged.
  - Pointers wrap modulo FIFO_DEPTH. count is the pointer difference, range 0..FIFO_DEPTH.
- Frame latency: CHECK occurs 1 cycle after the 11th fall_edge; data is at dout 2 cycles after the 11th fall_edge.
- Reset mid-frame or mid-FIFO discards everything. No pulses are generated by the reset itself.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, DPS, CHECK}
  - constants FRAME_BITS=11, START_BIT=0, STOP_BIT=1, LAST_BIT_IDX=9
  - odd_parity_ok(data, parity) function
- Sub-module ps2_sync_fifo, parametrised by WIDTH and DEPTH, with ports push, pop, din, dout, empty, full, count, clk and reset. It is instantiated once.
- The filter, FSM and checks stay in ps2_rx_fifo.

Test Plan:
1. With rx_en=1, send a frame of 0x1C with parity 0 and stop 1 -> dout=0x1C, empty=0, count=1, no error pulses. Then rd_en for 1 cycle -> empty=1, count=0.
2. Send 0x1C with parity bit 1 -> parity_err pulses exactly once, count stays 0, busy returns to 0.
3. Send 0x1C with stop bit 0 -> frame_err pulses once, FIFO unchanged. Then send 0xF0 with parity 1 -> dout=0xF0.
4. Send 4 bits of a frame, then hold ps2c high for TIMEOUT_CYC+10 cycles -> frame_err pulses once and busy=0. A following full 0x5A frame is received intact.
5. FIFO_DEPTH=4: send 0x01..0x04 without reading -> full=1, count=4. Send 0x05 -> overflow pulses, dout=0x01. Four pops return 01, 02, 03, 04, then empty=1.
6. Inject ps2c low glitches of FILTER_LEN-1 cycles mid-frame -> no extra shifts, and the frame is received correctly. Separately, assert reset mid-frame -> all outputs return to reset values and the next frame is received correctly.
